// File: rtl/fir_decim_fifo_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fir_decim_fifo_if : sample input and drained-output handshake bundle     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface fir_decim_fifo_if #(
  parameter int DEPTH = 8
);
  localparam int c_LW = $clog2(DEPTH) + 1;

  logic signed [15:0] din;
  logic signed [15:0] out_data;
  logic               out_valid;
  logic               out_ready;
  logic [c_LW-1:0]    level;
  logic               overflow;

  modport master (
    output din, out_ready,
    input  out_data, out_valid, level, overflow
  );

  modport slave (
    input  din, out_ready,
    output out_data, out_valid, level, overflow
  );
endinterface
`default_nettype wire

// File: rtl/fir_decim_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fir_decim_fifo : drops FIR warm-up output, decimates by DECIM (pick or   |
// | average when FIR_DECIM_AVG_EN is defined) and buffers kept samples.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module fir_decim_fifo #(
  parameter int DECIM  = 4,
  parameter int WARMUP = 13,
  parameter int DEPTH  = 8
) (
  input wire             clk,
  input wire             rst,
  fir_decim_fifo_if.slave bus
);
  localparam int c_PW   = $clog2(DECIM);
  localparam int c_AW   = $clog2(DEPTH);
  localparam int c_LW   = c_AW + 1;
  localparam int c_CW   = $clog2(WARMUP + 1);
`ifdef FIR_DECIM_AVG_EN
  localparam int c_ACCW = 16 + c_PW;
  localparam logic [c_PW-1:0] c_KEEP_PHASE = c_PW'(DECIM - 1);
`else
  localparam logic [c_PW-1:0] c_KEEP_PHASE = '0;
`endif

  typedef enum logic [0:0] {
    ST_WARM = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [c_CW-1:0]    r_warm_cnt;
  logic [c_CW-1:0]    w_warm_cnt_nxt;
  logic [c_PW-1:0]    r_phase;
  logic               w_keep;
  logic signed [15:0] w_kept_data;
  logic signed [15:0] r_kept_data;
  logic               r_kept_vld;

  logic signed [15:0] r_mem [DEPTH];
  logic [c_AW-1:0]    r_wr_ptr;
  logic [c_AW-1:0]    r_rd_ptr;
  logic [c_LW-1:0]    r_level;
  logic               r_overflow;
  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_WARM;
      r_warm_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_warm_cnt <= w_warm_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_warm_cnt_nxt = r_warm_cnt;
    w_keep         = 1'b0;
    case (r_state)
      ST_WARM: begin
        w_warm_cnt_nxt = r_warm_cnt + 1'b1;
        if (r_warm_cnt == c_CW'(WARMUP - 1)) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        w_keep = (r_phase == c_KEEP_PHASE);
      end
      default: w_state_nxt = ST_WARM;
    endcase
  end

  // Phase sits at zero throughout WARM, so RUN always starts on phase 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_phase <= '0;
    end else if (r_state == ST_RUN) begin
      r_phase <= r_phase + 1'b1;
    end
  end

`ifdef FIR_DECIM_AVG_EN
  logic signed [c_ACCW-1:0] r_acc;
  logic signed [c_ACCW-1:0] w_din_ext;
  logic signed [c_ACCW-1:0] w_sum;

  always_comb begin
    w_din_ext   = {{c_PW{bus.din[15]}}, bus.din};
    w_sum       = r_acc + w_din_ext;
    w_kept_data = 16'(w_sum >>> c_PW);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
    end else if (r_state == ST_RUN) begin
      r_acc <= (r_phase == '0) ? w_din_ext : w_sum;
    end
  end
`else
  always_comb begin
    w_kept_data = bus.din;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_kept_vld  <= 1'b0;
      r_kept_data <= '0;
    end else begin
      r_kept_vld  <= w_keep;
      r_kept_data <= w_kept_data;
    end
  end

  // A pop on a full FIFO frees the slot the incoming push needs.
  always_comb begin
    w_full  = (r_level == c_LW'(DEPTH));
    w_empty = (r_level == '0);
    w_pop   = !w_empty && bus.out_ready;
    w_push  = r_kept_vld && (!w_full || w_pop);
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= r_kept_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
      if (r_kept_vld && w_full && !w_pop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign bus.out_valid = !w_empty;
  assign bus.out_data  = w_empty ? 16'sd0 : r_mem[r_rd_ptr];
  assign bus.level     = r_level;
  assign bus.overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_fir_decim_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fir_decim_fifo : scoreboard bench for the decimating output FIFO      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_fir_decim_fifo;
  localparam int DECIM  = 4;
  localparam int WARMUP = 13;
  localparam int DEPTH  = 8;
  localparam int PW     = 2;

  typedef struct {
    int          cyc;
    logic [15:0] data;
  } pend_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fir_decim_fifo_if #(.DEPTH(DEPTH)) bus ();

  fir_decim_fifo #(
    .DECIM (DECIM),
    .WARMUP(WARMUP),
    .DEPTH (DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  pend_t       pend_q[$];
  logic [15:0] exp_q[$];
  logic [15:0] popped_q[$];
  int          vec_q[$];
  logic        exp_ovf = 1'b0;
  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          k = 0;
  int          acc = 0;
  bit          mon_en = 1'b0;
  bit          hit = 1'b0;
  logic        stall_prev = 1'b0;
  logic [15:0] prev_data = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // mode: 0 ready low, 1 ready high, 2 random, 3 raise ready on a full-FIFO push
  task automatic cyc_drive(input bit r, input int mode);
    int    j;
    int    v;
    pend_t p;
    @(posedge clk);
    #1;
    cyc++;
    rst = r;
    if (r) begin
      k = 0;
      bus.din = '0;
    end else begin
      v = 32'h7FFF;
      if (k >= WARMUP) begin
        j = k - WARMUP;
        v = (j < vec_q.size()) ? vec_q[j] : j + 1;
`ifdef FIR_DECIM_AVG_EN
        if (j % DECIM == 0) acc = v;
        else acc += v;
        if (j % DECIM == DECIM - 1) begin
          p.cyc = cyc + 1; p.data = 16'(acc >>> PW); pend_q.push_back(p);
        end
`else
        if (j % DECIM == 0) begin
          p.cyc = cyc + 1; p.data = 16'(v); pend_q.push_back(p);
        end
`endif
      end
      bus.din = 16'(v);
      k++;
    end
    case (mode)
      0: bus.out_ready = 1'b0;
      1: bus.out_ready = 1'b1;
      2: bus.out_ready = 1'($urandom_range(0, 1));
      default: begin
        if (!hit && exp_q.size() == DEPTH && pend_q.size() != 0 && pend_q[0].cyc == cyc) hit = 1'b1;
        bus.out_ready = hit;
      end
    endcase
  endtask

  always @(negedge clk) begin
    int sz;
    bit pop;
    bit push;
    if (mon_en) begin
      sz = exp_q.size();
      check("out_valid", 32'(bus.out_valid), 32'(sz != 0));
      check("level", 32'(bus.level), sz);
      check("overflow", 32'(bus.overflow), 32'(exp_ovf));
      if (sz != 0) check("out_data", 32'(bus.out_data), 32'(exp_q[0]));
      if (stall_prev) check("hold_data", 32'(bus.out_data), 32'(prev_data));
      pop  = (sz != 0) && bus.out_ready;
      push = (pend_q.size() != 0) && (pend_q[0].cyc == cyc);
      if (rst) begin
        exp_q.delete();
        pend_q.delete();
        exp_ovf    = 1'b0;
        stall_prev = 1'b0;
      end else begin
        stall_prev = (sz != 0) && !bus.out_ready;
        prev_data  = bus.out_data;
        if (pop) begin
          popped_q.push_back(bus.out_data);
          void'(exp_q.pop_front());
        end
        if (push) begin
          if (sz == DEPTH && !pop) exp_ovf = 1'b1;
          else exp_q.push_back(pend_q[0].data);
          void'(pend_q.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] first4 [4];
    int          base;
    rst = 1'b1;
    bus.din = '0;
    bus.out_ready = 1'b0;
`ifdef FIR_DECIM_AVG_EN
    base = 2;
`else
    base = 1;
`endif

    cyc_drive(1'b1, 0);
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_level", 32'(bus.level), 0);
    check("rst_overflow", 32'(bus.overflow), 0);
    check("rst_out_data", 32'(bus.out_data), 0);
    mon_en = 1'b1;

    // warm-up discard followed by the ramp, consumer always ready
    popped_q.delete();
    for (int i = 0; i < 60; i++) cyc_drive(1'b0, 1);
    for (int i = 0; i < 4; i++) begin
      first4[i] = (i < popped_q.size()) ? popped_q[i] : 16'hDEAD;
      check("ramp_seq", 32'(first4[i]), 32'(base + 4 * i));
    end

    // full FIFO with push and pop on the same edge
    cyc_drive(1'b1, 0);
    hit = 1'b0;
    for (int i = 0; i < 120 && !hit; i++) cyc_drive(1'b0, 3);
    check("full_push_seen", 32'(hit), 1);
    check("full_push_level", 32'(bus.level), DEPTH);
    cyc_drive(1'b0, 1);
    check("full_push_level_after", 32'(bus.level), DEPTH);
    check("full_push_no_ovf", 32'(bus.overflow), 0);
    for (int i = 0; i < 20; i++) cyc_drive(1'b0, 1);

    // fill past capacity, then drain
    cyc_drive(1'b1, 0);
    for (int i = 0; i < 55; i++) cyc_drive(1'b0, 0);
    check("fill_level", 32'(bus.level), DEPTH);
    check("fill_overflow", 32'(bus.overflow), 1);
    popped_q.delete();
    for (int i = 0; i < 40 && bus.level != 0; i++) cyc_drive(1'b0, 1);
    check("drain_empty", 32'(bus.level), 0);
    for (int i = 0; i < 8; i++)
      check("drain_order", 32'((i < popped_q.size()) ? popped_q[i] : 16'hDEAD), 32'(base + 4 * i));

    // reset in the middle of a partially drained, overflowed FIFO
    cyc_drive(1'b1, 0);
    for (int i = 0; i < 55; i++) cyc_drive(1'b0, 0);
    for (int i = 0; i < 30 && exp_q.size() != 5; i++) cyc_drive(1'b0, 1);
    check("pre_rst_level", 32'(bus.level), 5);
    check("pre_rst_overflow", 32'(bus.overflow), 1);
    rst = 1'b1;
    bus.out_ready = 1'b0;
    k = 0;
    cyc_drive(1'b0, 1);
    check("mid_rst_level", 32'(bus.level), 0);
    check("mid_rst_overflow", 32'(bus.overflow), 0);
    check("mid_rst_out_valid", 32'(bus.out_valid), 0);
    for (int i = 0; i < 14; i++) begin
      cyc_drive(1'b0, 1);
      check("rewarm_idle", 32'(bus.out_valid), 0);
    end
    cyc_drive(1'b0, 1);
    check("rewarm_first_valid", 32'(bus.out_valid), 1);
    check("rewarm_first_data", 32'(bus.out_data), base);

    // random backpressure
    cyc_drive(1'b1, 0);
    for (int i = 0; i < 200; i++) cyc_drive(1'b0, 2);
    for (int i = 0; i < 30; i++) cyc_drive(1'b0, 1);

`ifdef FIR_DECIM_AVG_EN
    // floor-rounded averaging of signed inputs
    vec_q = '{-1, -2, -3, -4, 3, 3, 3, 4};
    cyc_drive(1'b1, 0);
    popped_q.delete();
    for (int i = 0; i < 30; i++) cyc_drive(1'b0, 1);
    check("avg_neg", 32'((popped_q.size() > 0) ? popped_q[0] : 16'hDEAD), 32'h0000FFFD);
    check("avg_pos", 32'((popped_q.size() > 1) ? popped_q[1] : 16'hDEAD), 32'd3);
    vec_q.delete();
`endif

    @(posedge clk);
    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/fir_decim_fifo.md
# fir_decim_fifo

Output stage that sits directly downstream of the 9-tap FIR and consumes its `filtered_signal` output. The FIR has no reset and a fixed pipeline, so this block first discards its warm-up output. It then decimates the stream by `DECIM` and buffers the kept samples in a small FIFO. The FIFO is drained through a valid/ready handshake.

## Interface
- `DECIM`, 4: decimation factor; power of two, 2..64.
- `WARMUP`, 13: cycles after reset during which `din` is ignored. 13 = 9 delay-line taps + 4 adder-tree stages of the FIR.
- `DEPTH`, 8: FIFO entries; power of two, 2..256.
- `clk`  in  1: sole clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `din`  in  16: signed FIR output, one new sample every `clk`.
- `out_data`  out  16: signed head-of-FIFO sample.
- `out_valid`  out  1: `out_data` holds a valid sample.
- `out_ready`  in  1: consumer accepts the sample when `out_valid && out_ready`.
- `level`  out  $clog2(DEPTH)+1: current FIFO occupancy.
- `overflow`  out  1: sticky flag; a kept sample was dropped because the FIFO was full.

## Operation
- Reset values: `out_data`=0, `out_valid`=0, `level`=0, `overflow`=0. Warm-up counter=0, phase counter=0, accumulator=0.
- **WARM state:**
  - Counts `clk` cycles after `rst` deasserts.
  - `din` is ignored while the counter is below `WARMUP`.
  - On the cycle the counter reaches `WARMUP`, the block moves to RUN with phase=0.
  - WARM is never re-entered except via `rst`.
- **RUN state:**
  - The phase counter increments each cycle and wraps from DECIM-1 to 0.
  - The kept sample is formed per Configuration.
- Push rule: the kept sample is registered one cycle, then written to the FIFO tail.
- Pop rule: a pop occurs on any cycle with `out_valid && out_ready`.
- Full FIFO:
  - Push with no pop: the sample is dropped, `overflow` is set and stays set until `rst`, and `level` is unchanged.
  - Push with a simultaneous pop: both succeed and `level` is unchanged.
- Empty FIFO: `out_ready` is a don't-care and `out_valid`=0.
- Push and pop in the same cycle on a non-empty, non-full FIFO: `level` is unchanged.
- Pointers wrap modulo `DEPTH`. `level` ranges 0..DEPTH.
- `out_valid` only drops when the last entry is popped. `out_data` holds steady while `out_valid && !out_ready`.
- `rst` mid-operation:
  - Flushes the FIFO, clears `overflow`, and returns to WARM on the next edge.
  - Any in-flight kept sample is discarded.

## Timing
- First kept sample: `din` sampled on RUN cycle phase 0 (pick mode) is in the FIFO at edge +2 and visible as `out_valid`=1 at edge +2. Total latency from capture to `out_valid` is 2 cycles.
- Steady state: one push every `DECIM` cycles. A consumer holding `out_ready`=1 keeps `level` ≤ 1.
- `level` and `overflow` update on the same edge as the FIFO write or read that changes them.
- Single clock domain; no combinational path from `out_ready` to `out_valid`.

## Configuration
- `FIR_DECIM_AVG_EN` defined (averaging mode):
  - The kept sample is the mean of the `DECIM` samples at phases 0..DECIM-1.
  - The accumulator is signed, 16+log2(DECIM) bits, cleared at phase 0.
  - At phase DECIM-1 the result is (acc + din) arithmetically shifted right by log2(DECIM), which rounds toward −∞.
  - Latency to `out_valid` is measured from the phase DECIM-1 sample.
- Undefined (pick mode): the kept sample is the `din` present at phase 0. There is no accumulator.

## Test plan
- Warm-up discard: reset, drive `din`=16'h7FFF for 13 cycles, then a ramp starting at 1 with `out_ready`=1. The 16'h7FFF values never appear; pick mode yields 1, 5, 9, 13…
- Averaging (`FIR_DECIM_AVG_EN`, DECIM=4): `din` sequence −1, −2, −3, −4. Expect `out_data`=−3 (−10>>>2). Sequence 3, 3, 3, 4 yields 3.
- Fill/overflow: `out_ready`=0 and 9 kept samples with DEPTH=8. Expect `level`=8, `overflow`=1, and samples 1–8 retained. Then raise `out_ready`: the 8 samples drain in order and `level` reaches 0.
- Full with simultaneous push and pop: on the push cycle, `level` stays 8, `overflow` stays 0, and order is preserved.
- Backpressure: toggle `out_ready` randomly 50%. `out_data` is stable while stalled, with no loss or duplication as long as `level` < DEPTH.
- Mid-run reset: assert `rst` with `level`=5 and `overflow`=1. Next cycle `level`=0, `overflow`=0, `out_valid`=0, and 13 warm-up cycles are re-observed.
